// File: rtl/tpa_pkg.sv
// tpa_pkg: shared widths, command encoding and enums for the TPA register arbiter.
package tpa_pkg;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 8;
   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;
   typedef enum logic [1:0] {IDLE, ACC_RIM, ACC_TWP, RESP} state_e;
   typedef enum logic {OWN_RIM, OWN_TWP} owner_e;
endpackage

// File: rtl/tpa_reg_arbiter_if.sv
// tpa_reg_arbiter_if: RIM (cfg_*) and TWP (twp_*) register ports plus the contention count.
interface tpa_reg_arbiter_if import tpa_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) ();
   logic              cfg_req;
   logic              cfg_cmd;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_wdata;
   logic              cfg_rdy;
   logic [DATA_W-1:0] cfg_rdata;
   logic              twp_req;
   logic              twp_cmd;
   logic [ADDR_W-1:0] twp_addr;
   logic [DATA_W-1:0] twp_wdata;
   logic              twp_rdy;
   logic [DATA_W-1:0] twp_rdata;
   logic [CNT_W-1:0]  conflict_cnt;
   modport master (
      output cfg_req, cfg_cmd, cfg_addr, cfg_wdata, twp_req, twp_cmd, twp_addr, twp_wdata,
      input  cfg_rdy, cfg_rdata, twp_rdy, twp_rdata, conflict_cnt
   );
   modport slave (
      input  cfg_req, cfg_cmd, cfg_addr, cfg_wdata, twp_req, twp_cmd, twp_addr, twp_wdata,
      output cfg_rdy, cfg_rdata, twp_rdy, twp_rdata, conflict_cnt
   );
endinterface

// File: rtl/tpa_reg_file.sv
// tpa_reg_file: single-port register array, synchronous write and registered read, storage not reset.
module tpa_reg_file #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/tpa_reg_arbiter.sv
// tpa_reg_arbiter: arbitrates RIM and TWP access to the shared 256x16 register file.
// TPA_ARB_ROUND_ROBIN_EN selects alternating grants on contention; default is fixed TWP priority.
module tpa_reg_arbiter import tpa_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 2**ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic              clk,
   input logic              reset,
   tpa_reg_arbiter_if.slave bus
);
   state_e            state_q, state_d;
   owner_e            last_q, last_d;
   logic              cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d, rf_addr;
   logic [DATA_W-1:0] wdata_q, wdata_d, rf_rdata;
   logic [DATA_W-1:0] cfg_rdata_q, cfg_rdata_d, twp_rdata_q, twp_rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              both, grant_twp, rf_we;
   assign both = bus.cfg_req & bus.twp_req;
`ifdef TPA_ARB_ROUND_ROBIN_EN
   assign grant_twp = bus.twp_req & (~bus.cfg_req | (last_q == OWN_RIM));
`else
   assign grant_twp = bus.twp_req;
`endif
   // The read address is presented in IDLE so the registered read is ready during ACC.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      cfg_rdata_d = cfg_rdata_q;
      twp_rdata_d = twp_rdata_q;
      rf_we       = 1'b0;
      rf_addr     = addr_q;
      case (state_q)
         IDLE: begin
            rf_addr = grant_twp ? bus.twp_addr : bus.cfg_addr;
            if (bus.cfg_req | bus.twp_req) begin
               state_d = grant_twp ? ACC_TWP : ACC_RIM;
               cmd_d   = grant_twp ? bus.twp_cmd : bus.cfg_cmd;
               addr_d  = rf_addr;
               wdata_d = grant_twp ? bus.twp_wdata : bus.cfg_wdata;
            end
            if (both && cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end
         ACC_RIM, ACC_TWP: begin
            state_d = RESP;
            rf_we   = cmd_q == CMD_WRITE;
            last_d  = state_q == ACC_TWP ? OWN_TWP : OWN_RIM;
            if (cmd_q == CMD_READ && state_q == ACC_RIM) cfg_rdata_d = rf_rdata;
            if (cmd_q == CMD_READ && state_q == ACC_TWP) twp_rdata_d = rf_rdata;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= OWN_RIM;
         cmd_q       <= CMD_READ;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         cfg_rdata_q <= '0;
         twp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         cfg_rdata_q <= cfg_rdata_d;
         twp_rdata_q <= twp_rdata_d;
      end
   end
   tpa_reg_file #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_rf (
      .clk   (clk),
      .we    (rf_we),
      .addr  (rf_addr),
      .wdata (wdata_q),
      .rdata (rf_rdata)
   );
   assign bus.cfg_rdy      = (state_q == RESP) && (last_q == OWN_RIM);
   assign bus.twp_rdy      = (state_q == RESP) && (last_q == OWN_TWP);
   assign bus.cfg_rdata    = cfg_rdata_q;
   assign bus.twp_rdata    = twp_rdata_q;
   assign bus.conflict_cnt = cnt_q;
endmodule
